// File: rtl/leaderboard_pkg.sv
// Shared types and defaults for the top-N leaderboard.
package leaderboard_pkg;

  localparam int unsigned LbScoreW = 32;
  localparam int unsigned LbDepth  = 4;
  localparam int unsigned LbTagW   = 8;

  // Commit-processing sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StShift,
    StWrite,
    StDone
  } lb_state_t;

  // Rank code reported when a score does not make the table.
  function automatic int unsigned rank_none(input int unsigned depth);
    return depth;
  endfunction

endpackage

// File: rtl/leaderboard_slot.sv
// One leaderboard entry: valid flag, score and player tag, with clear and load.
module leaderboard_slot #(
  parameter int unsigned SCORE_W = 32,
  parameter int unsigned TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               valid_i,
  input  logic [SCORE_W-1:0] score_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               valid_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [TAG_W-1:0]   tag_o
);

  logic               valid_q;
  logic [SCORE_W-1:0] score_q;
  logic [TAG_W-1:0]   tag_q;

  // Entry register; clear has priority over load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      score_q <= '0;
      tag_q   <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      score_q <= '0;
      tag_q   <= '0;
    end else if (load_i) begin
      valid_q <= valid_i;
      score_q <= score_i;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign score_o = score_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/leaderboard_top_n.sv
// Sorted best-DEPTH score table with a session-best tracker. Commits are inserted by a
// small sequencer: scan for the insertion slot, ripple lower entries down, then write.
module leaderboard_top_n
  import leaderboard_pkg::*;
#(
  parameter int unsigned SCORE_W = LbScoreW,
  parameter int unsigned DEPTH   = LbDepth,
  parameter int unsigned TAG_W   = LbTagW,
  localparam int unsigned IdxW   = $clog2(DEPTH),
  localparam int unsigned RankW  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [SCORE_W-1:0] live_points,
  output logic [SCORE_W-1:0] live_best,
  input  logic               commit_valid,
  output logic               commit_ready,
  input  logic [SCORE_W-1:0] commit_score,
  input  logic [TAG_W-1:0]   commit_tag,
  output logic               done,
  output logic [RankW-1:0]   rank,
  input  logic [IdxW-1:0]    rd_idx,
  output logic [SCORE_W-1:0] rd_score,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid
);

  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(DEPTH - 1);
  localparam logic [RankW-1:0] RankNone = RankW'(rank_none(DEPTH));

  lb_state_t state_q, state_d;

  logic [IdxW-1:0]    k_q, k_d;
  logic [IdxW-1:0]    j_q, j_d;
  logic [IdxW-1:0]    pos_q, pos_d;
  logic [SCORE_W-1:0] cap_score_q, cap_score_d;
  logic [TAG_W-1:0]   cap_tag_q, cap_tag_d;
  logic [RankW-1:0]   rank_q, rank_d;
  logic [SCORE_W-1:0] live_best_q, live_best_d;

  logic               slot_valid [DEPTH];
  logic [SCORE_W-1:0] slot_score [DEPTH];
  logic [TAG_W-1:0]   slot_tag   [DEPTH];

  logic            accept;
  logic            hit;
  logic            scan_last;
  logic [IdxW-1:0] j_dec;
  logic            shift_last;
  logic            do_shift;
  logic            do_write;

  assign accept     = commit_valid & commit_ready;
  assign scan_last  = (k_q == LastIdx);
  // Strict compare: an equal score lands below the existing holder.
  assign hit        = ~slot_valid[k_q] | (cap_score_q > slot_score[k_q]);
  assign j_dec      = j_q - IdxW'(1);
  assign shift_last = (j_dec == pos_q);

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next-state; clear aborts any in-flight commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StScan;
      end
      StScan: begin
        if (hit) begin
          state_d = scan_last ? StWrite : StShift;
        end else if (scan_last) begin
          state_d = StDone;
        end
      end
      StShift: begin
        if (shift_last) state_d = StWrite;
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clr) state_d = StIdle;
  end

  // Sequencer outputs and table write strobes.
  always_comb begin
    commit_ready = (state_q == StIdle) & ~clr;
    done         = (state_q == StDone) & ~clr;
    do_shift     = (state_q == StShift) & ~clr;
    do_write     = (state_q == StWrite) & ~clr;
  end

  // Index counters, captured commit, rank and session best.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q         <= '0;
      j_q         <= '0;
      pos_q       <= '0;
      cap_score_q <= '0;
      cap_tag_q   <= '0;
      rank_q      <= '0;
      live_best_q <= '0;
    end else begin
      k_q         <= k_d;
      j_q         <= j_d;
      pos_q       <= pos_d;
      cap_score_q <= cap_score_d;
      cap_tag_q   <= cap_tag_d;
      rank_q      <= rank_d;
      live_best_q <= live_best_d;
    end
  end

  // Next-state for counters and captured commit; rank survives a clear.
  always_comb begin
    k_d         = k_q;
    j_d         = j_q;
    pos_d       = pos_q;
    cap_score_d = cap_score_q;
    cap_tag_d   = cap_tag_q;
    rank_d      = rank_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          k_d         = '0;
          cap_score_d = commit_score;
          cap_tag_d   = commit_tag;
        end
      end
      StScan: begin
        if (hit) begin
          pos_d = k_q;
          j_d   = LastIdx;
        end else if (scan_last) begin
          rank_d = RankNone;
        end else begin
          k_d = k_q + IdxW'(1);
        end
      end
      StShift: j_d = j_dec;
      StWrite: begin
        if (!clr) rank_d = RankW'(pos_q);
      end
      default: ;
    endcase
  end

  // Session best: running max of live points and the table leader.
  always_comb begin
    live_best_d = live_best_q;
    if (live_points > live_best_d) live_best_d = live_points;
    if (slot_valid[0] && (slot_score[0] > live_best_d)) live_best_d = slot_score[0];
    if (clr) live_best_d = '0;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic               load;
    logic               valid_in;
    logic [SCORE_W-1:0] score_in;
    logic [TAG_W-1:0]   tag_in;

    if (gi == 0) begin : g_head
      // The head slot is only ever written, never shifted into.
      assign load     = do_write & (pos_q == IdxW'(0));
      assign valid_in = 1'b1;
      assign score_in = cap_score_q;
      assign tag_in   = cap_tag_q;
    end else begin : g_body
      assign load     = (do_shift & (j_q == IdxW'(gi))) | (do_write & (pos_q == IdxW'(gi)));
      assign valid_in = do_write ? 1'b1        : slot_valid[gi-1];
      assign score_in = do_write ? cap_score_q : slot_score[gi-1];
      assign tag_in   = do_write ? cap_tag_q   : slot_tag[gi-1];
    end

    leaderboard_slot #(
      .SCORE_W(SCORE_W),
      .TAG_W  (TAG_W)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (clr),
      .load_i (load),
      .valid_i(valid_in),
      .score_i(score_in),
      .tag_i  (tag_in),
      .valid_o(slot_valid[gi]),
      .score_o(slot_score[gi]),
      .tag_o  (slot_tag[gi])
    );
  end

  assign live_best = live_best_q;
  assign rank      = rank_q;
  assign rd_valid  = slot_valid[rd_idx];
  assign rd_score  = slot_score[rd_idx];
  assign rd_tag    = slot_tag[rd_idx];

endmodule

// File: tb/tb_leaderboard_top_n.sv
// Directed self-checking bench for leaderboard_top_n at default parameters.
module tb_leaderboard_top_n;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [31:0] live_points;
  logic [31:0] live_best;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_score;
  logic [7:0]  commit_tag;
  logic        done;
  logic [2:0]  rank;
  logic [1:0]  rd_idx;
  logic [31:0] rd_score;
  logic [7:0]  rd_tag;
  logic        rd_valid;

  int n_checks = 0;
  int n_errors = 0;

  leaderboard_top_n dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .live_points (live_points),
    .live_best   (live_best),
    .commit_valid(commit_valid),
    .commit_ready(commit_ready),
    .commit_score(commit_score),
    .commit_tag  (commit_tag),
    .done        (done),
    .rank        (rank),
    .rd_idx      (rd_idx),
    .rd_score    (rd_score),
    .rd_tag      (rd_tag),
    .rd_valid    (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_entry(input int idx, input logic v, input logic [31:0] s,
                             input logic [7:0] t, input string name);
    rd_idx = 2'(idx);
    #1;
    check_eq({name, "_valid"}, rd_valid, v);
    if (v) begin
      check_eq({name, "_score"}, rd_score, s);
      check_eq({name, "_tag"}, rd_tag, t);
    end
  endtask

  task automatic check_all_invalid(input string name);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      check_eq($sformatf("%s_inv%0d", name, i), rd_valid, 1'b0);
    end
  endtask

  // Called just after a negedge; returns just after the accepting posedge.
  task automatic start_commit(input logic [31:0] s, input logic [7:0] t, input logic hold);
    int w;
    w = 0;
    while (!commit_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check_eq("ready_timeout", commit_ready, 1'b1);
    commit_score = s;
    commit_tag   = t;
    commit_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) commit_valid = 1'b0;
  endtask

  // Cycles from accept to the done pulse; -1 if it never comes.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic commit_check(input logic [31:0] s, input logic [7:0] t, input int exp_lat,
                              input logic [2:0] exp_rank, input string name);
    int lat;
    start_commit(s, t, 1'b0);
    wait_done(lat);
    check_eq({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({name, "_rank"}, rank, exp_rank);
    @(negedge clk);
    check_eq({name, "_done_1cyc"}, done, 1'b0);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int lat;
    int n;
    int ready_hi;
    rst          = 1'b1;
    clr          = 1'b0;
    live_points  = '0;
    commit_valid = 1'b0;
    commit_score = '0;
    commit_tag   = '0;
    rd_idx       = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset state, then first commit into an empty table
    check_eq("rst_live_best", live_best, 0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_rank", rank, 0);
    check_eq("rst_ready", commit_ready, 1'b1);
    check_all_invalid("rst");
    commit_check(50, 1, 6, 0, "t1");
    check_entry(0, 1'b1, 50, 1, "t1_e0");
    check_entry(1, 1'b0, 0, 0, "t1_e1");
    check_entry(2, 1'b0, 0, 0, "t1_e2");
    check_entry(3, 1'b0, 0, 0, "t1_e3");

    // 2: build a sorted table from an empty start
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    commit_check(50, 1, 6, 0, "t2a");
    commit_check(80, 2, 6, 0, "t2b");
    commit_check(30, 3, 6, 2, "t2c");
    commit_check(60, 4, 6, 1, "t2d");
    check_entry(0, 1'b1, 80, 2, "t2_e0");
    check_entry(1, 1'b1, 60, 4, "t2_e1");
    check_entry(2, 1'b1, 50, 1, "t2_e2");
    check_entry(3, 1'b1, 30, 3, "t2_e3");

    // 3: full table, score too low; then a tie that must land below the holder
    commit_check(20, 5, 5, 4, "t3a");
    check_entry(3, 1'b1, 30, 3, "t3a_e3");
    check_entry(0, 1'b1, 80, 2, "t3a_e0");
    commit_check(60, 9, 6, 2, "t3b");
    check_entry(0, 1'b1, 80, 2, "t3b_e0");
    check_entry(1, 1'b1, 60, 4, "t3b_e1");
    check_entry(2, 1'b1, 60, 9, "t3b_e2");
    check_entry(3, 1'b1, 50, 1, "t3b_e3");

    // 4: session best tracks live points and the table leader, then clears
    check_eq("t4_best_leader", live_best, 80);
    for (int i = 0; i <= 100; i++) begin
      live_points = 32'(i);
      @(negedge clk);
      if (i == 50) check_eq("t4_best_at50", live_best, 80);
      if (i == 90) check_eq("t4_best_at90", live_best, 90);
    end
    check_eq("t4_best_peak", live_best, 100);
    live_points = 10;
    repeat (3) @(negedge clk);
    check_eq("t4_best_hold", live_best, 100);
    live_points = 0;
    clr = 1'b1;
    #1;
    check_eq("t4_ready_in_clr", commit_ready, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    check_eq("t4_best_clr", live_best, 0);
    check_all_invalid("t4");

    // 5a: clear during the shift phase aborts the commit
    commit_check(40, 1, 6, 0, "t5a");
    commit_check(30, 2, 6, 1, "t5b");
    start_commit(50, 3, 1'b0);
    @(negedge clk);  // scan
    @(negedge clk);  // shift
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_eq("t5_ready_after_clr", commit_ready, 1'b1);
    check_eq("t5_rank_kept", rank, 1);
    check_all_invalid("t5");
    count_dones(10, n);
    check_eq("t5_no_done", 64'(n), 0);

    // 5b: async reset mid-scan
    commit_check(40, 1, 6, 0, "t5c");
    commit_check(30, 2, 6, 1, "t5d");
    start_commit(10, 5, 1'b0);
    @(negedge clk);  // scan k=0
    rst = 1'b1;
    #1;
    check_eq("t5_rst_best", live_best, 0);
    check_eq("t5_rst_rank", rank, 0);
    check_eq("t5_rst_done", done, 1'b0);
    rd_idx = 0;
    #1;
    check_eq("t5_rst_e0", rd_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(10, n);
    check_eq("t5_rst_no_done", 64'(n), 0);
    check_eq("t5_rst_ready", commit_ready, 1'b1);

    // 6: commit_valid held high; inputs change after accept
    start_commit(70, 7, 1'b1);
    commit_score = 99;
    commit_tag   = 8;
    ready_hi = 0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      if (commit_ready) ready_hi++;
    end
    check_eq("t6a_lat", 64'(lat), 6);
    check_eq("t6a_ready_low", 64'(ready_hi), 0);
    check_eq("t6a_rank", rank, 0);
    check_eq("t6a_ready_in_done", commit_ready, 1'b0);
    @(negedge clk);
    check_eq("t6_ready_after_done", commit_ready, 1'b1);
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
    wait_done(lat);
    check_eq("t6b_lat", 64'(lat), 6);
    check_eq("t6b_rank", rank, 0);
    check_entry(0, 1'b1, 99, 8, "t6_e0");
    check_entry(1, 1'b1, 70, 7, "t6_e1");
    check_entry(2, 1'b0, 0, 0, "t6_e2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
